wrr_sched: RTL and testbench

WRR_SCHED -- requirements
Module: wrr_sched

---
 rtl/wrr_sched_pkg.sv | 10 +
 rtl/wrr_next_sel.sv | 36 +++
 rtl/wrr_sched.sv | 103 ++++++++++
 tb/tb_wrr_sched.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/wrr_sched_pkg.sv
// Shared constants for the weighted round-robin packet scheduler.
// State encodings stay plain 1-bit constants so older consumers can compare against them.
package wrr_sched_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam int DEFAULT_WEIGHT_C = 1;

endpackage

// File: rtl/wrr_next_sel.sv
// Circular priority search: finds the first eligible queue after start, wrapping through start.
// The start queue itself is the last candidate considered.
module wrr_next_sel
  import wrr_sched_pkg::*;
#(
  parameter int NUM_FIFO  = 3,
  parameter int SEL_WIDTH = $clog2(NUM_FIFO)
) (
  input  logic [NUM_FIFO-1:0]  eligible,
  input  logic [SEL_WIDTH-1:0] start,
  output logic [SEL_WIDTH-1:0] idx,
  output logic                 found
);

  logic [SEL_WIDTH-1:0] cand [NUM_FIFO];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIFO; gi++) begin : g_cand
      assign cand[gi] = SEL_WIDTH'((32'(start) + 1 + gi) % NUM_FIFO);
    end
  endgenerate

  // Walk from the farthest offset down so the nearest eligible queue wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = NUM_FIFO - 1; k >= 0; k--) begin
      if (eligible[cand[k]]) begin
        idx   = cand[k];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_sched.sv
// Weighted round-robin select/enable generator for a packet mux.
// Each grant allows weight[q] packets before moving on; one idle bubble follows every packet.
module wrr_sched
  import wrr_sched_pkg::*;
#(
  parameter int NUM_FIFO       = 3,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int DEFAULT_WEIGHT = DEFAULT_WEIGHT_C,
  parameter int SEL_WIDTH      = $clog2(NUM_FIFO)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_FIFO-1:0]     fifo_tvalid,
  input  logic                    out_tvalid,
  input  logic                    out_tready,
  input  logic                    out_tlast,
  input  logic                    cfg_wr_en,
  input  logic [SEL_WIDTH-1:0]    cfg_wr_addr,
  input  logic [WEIGHT_WIDTH-1:0] cfg_wr_data,
  output logic [SEL_WIDTH-1:0]    sel_out,
  output logic                    en_out
);

  logic [0:0]              state_reg, state_next;
  logic [SEL_WIDTH-1:0]    sel_reg, sel_next;
  logic [WEIGHT_WIDTH-1:0] credit_reg, credit_next;
  logic [WEIGHT_WIDTH-1:0] weight_reg [NUM_FIFO];
  logic [NUM_FIFO-1:0]     eligible;
  logic [SEL_WIDTH-1:0]    hit_idx;
  logic                    hit_found;
  logic                    pkt_end;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIFO; gi++) begin : g_elig
      assign eligible[gi] = fifo_tvalid[gi] && (weight_reg[gi] != '0);
    end
  endgenerate

  wrr_next_sel #(
    .NUM_FIFO  (NUM_FIFO),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_next_sel (
    .eligible (eligible),
    .start    (sel_reg),
    .idx      (hit_idx),
    .found    (hit_found)
  );

  assign pkt_end = out_tvalid && out_tready && out_tlast;

  // Out-of-range addresses match no queue and so fall away naturally.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FIFO; i++) begin
      if (rst) begin
        weight_reg[i] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
      end else if (cfg_wr_en && (cfg_wr_addr == SEL_WIDTH'(i))) begin
        weight_reg[i] <= cfg_wr_data;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    credit_next = credit_reg;
    case (state_reg)
      ST_IDLE: begin
        if ((credit_reg != '0) && eligible[sel_reg]) begin
          state_next = ST_SEND;
        end else if (hit_found) begin
          sel_next    = hit_idx;
          credit_next = weight_reg[hit_idx];
          state_next  = ST_SEND;
        end
      end
      default: begin
        if (pkt_end) begin
          state_next = ST_IDLE;
          if (credit_reg != '0) begin
            credit_next = credit_reg - WEIGHT_WIDTH'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      sel_reg    <= '0;
      credit_reg <= '0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      credit_reg <= credit_next;
    end
  end

  assign sel_out = sel_reg;
  assign en_out  = (state_reg == ST_SEND);

endmodule

// File: tb/tb_wrr_sched.sv
// Directed bench for wrr_sched: grant order, weights, stalls, reset and config writes.
module tb_wrr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] fifo_tvalid;
  logic       out_tvalid, out_tready, out_tlast;
  logic       cfg_wr_en;
  logic [1:0] cfg_wr_addr;
  logic [7:0] cfg_wr_data;
  logic [1:0] sel_out;
  logic       en_out;

  int n_total = 0;
  int n_pass  = 0;

  int order_a [4] = '{1, 2, 0, 0};
  int order_b [3] = '{2, 0, 0};
  int order_c [3] = '{1, 2, 0};

  wrr_sched dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_tvalid (fifo_tvalid),
    .out_tvalid  (out_tvalid),
    .out_tready  (out_tready),
    .out_tlast   (out_tlast),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_addr (cfg_wr_addr),
    .cfg_wr_data (cfg_wr_data),
    .sel_out     (sel_out),
    .en_out      (en_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) begin
      n_pass++;
      $display("ok   %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_out(input logic v);
    out_tvalid = v;
    out_tready = v;
    out_tlast  = v;
  endtask

  task automatic wr_weight(input logic [1:0] addr, input logic [7:0] data);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = addr;
    cfg_wr_data = data;
    tick();
    cfg_wr_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fifo_tvalid = '0; set_out(1'b0);
    cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    tick(); tick();
    check("reset_en", int'(en_out), 0);
    check("reset_sel", int'(sel_out), 0);
    rst = 1'b0;

    // Nothing valid: stay idle; queue 0 valid -> grant one cycle later.
    repeat (3) tick();
    check("idle_no_valid_en", int'(en_out), 0);
    fifo_tvalid = 3'b001;
    tick();
    check("first_grant_en", int'(en_out), 1);
    check("first_grant_sel", int'(sel_out), 0);
    fifo_tvalid = 3'b000;
    tick(); tick();
    check("valid_drop_hold_en", int'(en_out), 1);
    set_out(1'b1);
    tick();
    check("pkt_end_bubble_en", int'(en_out), 0);
    set_out(1'b0);

    // tlast stalled without tready: single decrement at the handshake.
    wr_weight(2'd0, 8'd2);
    fifo_tvalid = 3'b001;
    tick();
    check("stall_grant_sel", int'(sel_out), 0);
    out_tvalid = 1'b1; out_tlast = 1'b1; out_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall_hold_en[%0d]", i), int'(en_out), 1);
    end
    out_tready = 1'b1;
    tick();
    check("stall_release_en", int'(en_out), 0);
    set_out(1'b0);
    fifo_tvalid = 3'b011;
    tick();
    check("stall_cont_en", int'(en_out), 1);
    check("stall_cont_sel", int'(sel_out), 0);
    set_out(1'b1);
    tick();
    set_out(1'b0);
    tick();
    check("stall_next_sel", int'(sel_out), 1);
    set_out(1'b1);
    tick();
    set_out(1'b0);
    fifo_tvalid = 3'b000;

    // Weights {2,1,1}, all valid: 1,2,0,0 repeating with bubbles.
    rst = 1'b1; tick(); rst = 1'b0;
    wr_weight(2'd0, 8'd2);
    fifo_tvalid = 3'b111; set_out(1'b1);
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("wrr_en[%0d]", i), int'(en_out), (i % 2 == 0) ? 1 : 0);
      check($sformatf("wrr_sel[%0d]", i), int'(sel_out), order_a[(i / 2) % 4]);
    end

    // Weight[1] cleared mid-packet: packet finishes, queue 1 never returns.
    set_out(1'b0);
    tick();
    check("w0_grant_sel", int'(sel_out), 1);
    wr_weight(2'd1, 8'd0);
    check("w0_inflight_en", int'(en_out), 1);
    check("w0_inflight_sel", int'(sel_out), 1);
    set_out(1'b1);
    tick();
    check("w0_end_en", int'(en_out), 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("w0_en[%0d]", i), int'(en_out), (i % 2 == 0) ? 1 : 0);
      check($sformatf("w0_sel[%0d]", i), int'(sel_out), order_b[(i / 2) % 3]);
    end

    // Only queue 2 valid, weight 3: stays on queue 2 across reloads.
    set_out(1'b0); fifo_tvalid = 3'b000;
    wr_weight(2'd2, 8'd3);
    fifo_tvalid = 3'b100; set_out(1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("q2_en[%0d]", i), int'(en_out), (i % 2 == 0) ? 1 : 0);
      check($sformatf("q2_sel[%0d]", i), int'(sel_out), 2);
    end
    set_out(1'b0); fifo_tvalid = 3'b101;
    tick();
    check("q2_exhaust_sel", int'(sel_out), 0);

    // Reset mid-packet on queue 2.
    set_out(1'b1);
    tick();
    set_out(1'b0); fifo_tvalid = 3'b100;
    tick();
    check("rst_pre_sel", int'(sel_out), 2);
    tick();
    check("rst_pre_en", int'(en_out), 1);
    rst = 1'b1;
    tick();
    check("rst_mid_en", int'(en_out), 0);
    check("rst_mid_sel", int'(sel_out), 0);
    rst = 1'b0;
    fifo_tvalid = 3'b111; set_out(1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rst_w1_sel[%0d]", i), int'(sel_out), order_c[(i / 2) % 3]);
    end

    // Out-of-range weight write is ignored.
    set_out(1'b0); fifo_tvalid = 3'b000;
    wr_weight(2'd3, 8'd0);
    fifo_tvalid = 3'b111; set_out(1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("oor_sel[%0d]", i), int'(sel_out), order_c[(i / 2) % 3]);
    end

    // Reload coinciding with a write to the same queue uses the old weight.
    set_out(1'b0); fifo_tvalid = 3'b010;
    wr_weight(2'd1, 8'd3);
    check("wr_reload_sel", int'(sel_out), 1);
    check("wr_reload_en", int'(en_out), 1);
    set_out(1'b1);
    tick();
    set_out(1'b0); fifo_tvalid = 3'b011;
    tick();
    check("wr_reload_next_sel", int'(sel_out), 0);
    check("wr_reload_next_en", int'(en_out), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
